// File: rtl/music_box_pkg.sv
// Shared types and constants for the music box mode sequencer and the mode modules
// that decode its current_state broadcast.
package music_box_pkg;

  typedef enum logic [4:0] {
    IDLE    = 5'd0,
    SONG1   = 5'd1,
    SONG2   = 5'd2,
    PLAYREC = 5'd3,
    MAKEREC = 5'd4
  } music_box_state_t;

  localparam int NUM_BUTTONS     = 4;

  localparam int DBG_STATE_LSB   = 0;
  localparam int DBG_LAST_LSB    = 8;
  localparam int DBG_COUNT_LSB   = 16;
  localparam int DBG_TIMEOUT_BIT = 31;

  function automatic logic is_active(input logic [4:0] state);
    return (state >= 5'd1) && (state <= 5'd4);
  endfunction

endpackage

// File: rtl/music_box_state_controller_debouncer.sv
// Per-key input conditioning: 2-flop synchroniser, tick-based debounce counter and a
// one-cycle press pulse on the debounced release->pressed transition.
module button_debouncer #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_button_n,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_flip;

  assign w_differ = r_sync2 ^ r_stable;
  // the flip happens on the DEBOUNCE_MS-th consecutive differing tick
  assign w_flip   = w_differ && i_tick && (r_cnt == CW'(DEBOUNCE_MS - 1));

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_button_n;
      r_sync2 <= r_sync1;
      r_press <= w_flip && r_stable;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else if (i_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/music_box_state_controller.sv
// Top-level mode sequencer: debounced key presses select a mode, completion or abort
// returns to IDLE. Optional watchdog enabled by MUSICBOX_STATE_TIMEOUT_EN.
module music_box_state_controller
  import music_box_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int TIMEOUT_MS  = 60000
) (
  input  logic                   clock_50Mhz,
  input  logic                   reset_n,
  input  logic                   tick_1khz,
  input  logic [NUM_BUTTONS-1:0] button_n,
  input  logic [4:0]             state_complete,
  output logic [4:0]             current_state,
  output logic                   state_entered,
  output logic [31:0]            debug_string
);

  music_box_state_t       r_state;
  music_box_state_t       w_next;
  logic                   r_entered;
  logic [4:0]             r_last_exit;
  logic [7:0]             r_comp_cnt;
  logic [NUM_BUTTONS-1:0] w_press;
  logic                   w_done;
  logic                   w_abort;
  logic                   w_timeout;
  logic                   w_timeout_flag;
  logic                   w_exit_active;
  logic [31:0]            w_debug;
  logic                   w_unused;

  assign w_unused = state_complete[0];

  for (genvar k = 0; k < NUM_BUTTONS; k++) begin : g_db
    button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db (
      .clock_50Mhz (clock_50Mhz),
      .reset_n     (reset_n),
      .i_tick      (tick_1khz),
      .i_button_n  (button_n[k]),
      .o_press     (w_press[k])
    );
  end

  always_comb begin
    w_next        = r_state;
    w_done        = 1'b0;
    w_abort       = 1'b0;
    w_exit_active = 1'b0;
    case (r_state)
      IDLE: begin
        if      (w_press[0]) w_next = SONG1;
        else if (w_press[1]) w_next = SONG2;
        else if (w_press[2]) w_next = PLAYREC;
        else if (w_press[3]) w_next = MAKEREC;
      end
      SONG1: begin
        w_done  = state_complete[1];
        w_abort = w_press[0];
      end
      SONG2: begin
        w_done  = state_complete[2];
        w_abort = w_press[1];
      end
      PLAYREC: begin
        w_done  = state_complete[3];
        w_abort = w_press[2];
      end
      MAKEREC: begin
        w_done  = state_complete[4];
        w_abort = w_press[3];
      end
      default: w_next = IDLE;
    endcase
    if (is_active(r_state) && (w_done || w_abort || w_timeout)) begin
      w_next        = IDLE;
      w_exit_active = 1'b1;
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_entered   <= 1'b0;
      r_last_exit <= '0;
      r_comp_cnt  <= '0;
    end else begin
      r_state   <= w_next;
      r_entered <= (w_next != r_state);
      if (w_exit_active) r_last_exit <= r_state;
      if (w_exit_active && w_done) r_comp_cnt <= r_comp_cnt + 8'd1;
    end
  end

`ifdef MUSICBOX_STATE_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_timeout_flag;

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else if (w_next != r_state) begin
      r_wdog <= '0;
    end else if (is_active(r_state) && tick_1khz) begin
      r_wdog <= r_wdog + 16'd1;
    end
  end

  assign w_timeout = is_active(r_state) && (r_wdog == 16'(TIMEOUT_MS));

  // completion/abort in the same cycle take the exit, so no sticky flag then
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout_flag <= 1'b0;
    end else if (w_timeout && !w_done && !w_abort) begin
      r_timeout_flag <= 1'b1;
    end
  end

  assign w_timeout_flag = r_timeout_flag;
`else
  assign w_timeout      = 1'b0;
  assign w_timeout_flag = 1'b0;
`endif

  always_comb begin
    w_debug                          = '0;
    w_debug[DBG_STATE_LSB +: 5]      = r_state;
    w_debug[DBG_LAST_LSB +: 5]       = r_last_exit;
    w_debug[DBG_COUNT_LSB +: 8]      = r_comp_cnt;
    w_debug[DBG_TIMEOUT_BIT]         = w_timeout_flag;
  end

  assign current_state = r_state;
  assign state_entered = r_entered;
  assign debug_string  = w_debug;

endmodule

// File: tb/tb_music_box_state_controller.sv
// Self-checking bench for music_box_state_controller: per-cycle comparison against a
// behavioural model plus directed literal checks; honours MUSICBOX_STATE_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_music_box_state_controller;

  localparam int DEB = 20;
  localparam int TMO = 100;

  logic        clock_50Mhz = 1'b0;
  logic        reset_n     = 1'b0;
  logic        tick_1khz   = 1'b0;
  logic [3:0]  button_n    = 4'hF;
  logic [4:0]  state_complete = 5'd0;
  logic [4:0]  current_state;
  logic        state_entered;
  logic [31:0] debug_string;

  int checks = 0;
  int errors = 0;
  int n_entered = 0;
  bit chk_en = 1'b0;

  music_box_state_controller #(.DEBOUNCE_MS(DEB), .TIMEOUT_MS(TMO)) dut (
    .clock_50Mhz    (clock_50Mhz),
    .reset_n        (reset_n),
    .tick_1khz      (tick_1khz),
    .button_n       (button_n),
    .state_complete (state_complete),
    .current_state  (current_state),
    .state_entered  (state_entered),
    .debug_string   (debug_string)
  );

  always #10 clock_50Mhz = ~clock_50Mhz;

  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(negedge clock_50Mhz);
      tcnt++;
      tick_1khz = (tcnt % 2 == 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "global timeout");
  end

  // ---------------- behavioural model ----------------
  int m_mode, m_last, m_cnt, m_wd;
  bit m_flag, m_ent;
  bit m_d1 [4];
  bit m_d2 [4];
  bit m_stable [4];
  int m_run [4];
  bit m_press [4];

  task automatic model_reset();
    m_mode = 0; m_last = 0; m_cnt = 0; m_wd = 0; m_flag = 0; m_ent = 0;
    for (int k = 0; k < 4; k++) begin
      m_d1[k] = 1; m_d2[k] = 1; m_stable[k] = 1; m_run[k] = 0; m_press[k] = 0;
    end
  endtask

  always @(posedge clock_50Mhz) begin : model
    int nxt;
    bit done_c, abort_c;
    bit np [4];
    logic [31:0] exp_dbg;
    if (!reset_n) begin
      model_reset();
    end else begin
      nxt = m_mode; done_c = 0; abort_c = 0;
      if (m_mode == 0) begin
        for (int k = 3; k >= 0; k--) if (m_press[k]) nxt = k + 1;
      end else begin
        done_c  = state_complete[m_mode];
        abort_c = m_press[m_mode-1];
        if (done_c || abort_c) nxt = 0;
`ifdef MUSICBOX_STATE_TIMEOUT_EN
        else if (m_wd == TMO) begin
          nxt = 0;
          m_flag = 1;
        end
`endif
        if (nxt == 0) m_last = m_mode;
        if (done_c) m_cnt = (m_cnt + 1) % 256;
      end
      m_ent = (nxt != m_mode);
      if (m_ent) m_wd = 0;
      else if (m_mode != 0 && tick_1khz) m_wd++;
      m_mode = nxt;
      for (int k = 0; k < 4; k++) begin
        np[k] = 0;
        if (m_d2[k] != m_stable[k]) begin
          if (tick_1khz) begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
              m_stable[k] = m_d2[k];
              m_run[k] = 0;
              np[k] = !m_stable[k];
            end
          end
        end else begin
          m_run[k] = 0;
        end
      end
      for (int k = 0; k < 4; k++) begin
        m_press[k] = np[k];
        m_d2[k] = m_d1[k];
        m_d1[k] = button_n[k];
      end
    end
    #1;
    exp_dbg = (32'(m_flag) << 31) | (32'(m_cnt) << 16) | (32'(m_last) << 8) | 32'(m_mode);
    if (state_entered) n_entered++;
    if (chk_en) begin
      checks++;
      if (current_state !== 5'(m_mode) || state_entered !== m_ent || debug_string !== exp_dbg) begin
        errors++;
        $display("FAIL model_cycle t=%0t: got state=%0d ent=%0b dbg=%h, want state=%0d ent=%0b dbg=%h",
                 $time, current_state, state_entered, debug_string, m_mode, m_ent, exp_dbg);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clock_50Mhz); while (!tick_1khz);
    end
    @(negedge clock_50Mhz);
  endtask

  task automatic wait_state(input logic [4:0] s, input int maxc, input string nm);
    bit found;
    found = 0;
    for (int i = 0; i < maxc && !found; i++) begin
      @(posedge clock_50Mhz); #2;
      if (current_state == s) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: state %0d not reached in %0d cycles, got %0d", nm, s, maxc, current_state);
    end
    @(negedge clock_50Mhz);
  endtask

  task automatic pulse_complete(input int idx);
    @(negedge clock_50Mhz);
    state_complete[idx] = 1'b1;
    @(negedge clock_50Mhz);
    state_complete[idx] = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    bit hit;
    @(posedge clock_50Mhz);
    chk_en = 1'b1;
    repeat (4) @(negedge clock_50Mhz);
    reset_n = 1'b1;

    // idle with no keys
    wait_ticks(1000);
    chk("idle_state", 32'(current_state), 32'd0);
    chk("idle_debug", debug_string, 32'd0);
    chk("idle_no_entered", 32'(n_entered), 32'd0);

    // glitch shorter than the debounce window
    button_n[3] = 1'b0;
    wait_ticks(5);
    button_n[3] = 1'b1;
    wait_ticks(30);
    chk("glitch_ignored", 32'(current_state), 32'd0);

    // key 3 held for 25 ticks -> MAKEREC about 20 ticks later
    button_n[3] = 1'b0;
    lat = 0; hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clock_50Mhz);
      if (tick_1khz) lat++;
      #2;
      if (current_state == 5'd4) hit = 1;
    end
    chk("key3_enter", 32'(current_state), 32'd4);
    chk("key3_latency_ok", 32'(lat >= 20 && lat <= 23), 32'd1);
    @(negedge clock_50Mhz);
    wait_ticks(3);
    button_n[3] = 1'b1;
    wait_ticks(25);
    chk("key3_one_pulse", 32'(n_entered), 32'd1);

    // foreign completion ignored, own completion exits
    pulse_complete(2);
    chk("foreign_complete_ignored", 32'(current_state), 32'd4);
    pulse_complete(4);
    chk("complete_to_idle", 32'(current_state), 32'd0);
    chk("complete_last", 32'(debug_string[12:8]), 32'd4);
    chk("complete_count", 32'(debug_string[23:16]), 32'd1);

    // keys 1 and 2 together -> SONG2, key 1 again aborts
    button_n[2:1] = 2'b00;
    wait_state(5'd2, 120, "dual_press_enter");
    wait_ticks(4);
    button_n[2:1] = 2'b11;
    wait_ticks(25);
    chk("dual_press_hold", 32'(current_state), 32'd2);
    button_n[1] = 1'b0;
    wait_state(5'd0, 120, "abort_to_idle");
    chk("abort_last", 32'(debug_string[12:8]), 32'd2);
    chk("abort_count_same", 32'(debug_string[23:16]), 32'd1);
    button_n[1] = 1'b1;
    wait_ticks(25);

    // asynchronous reset in the middle of PLAYREC
    button_n[2] = 1'b0;
    wait_state(5'd3, 120, "playrec_enter");
    button_n[2] = 1'b1;
    @(posedge clock_50Mhz);
    #5 reset_n = 1'b0;
    #1 chk("async_reset_state", 32'(current_state), 32'd0);
    chk("async_reset_debug", debug_string, 32'd0);
    repeat (2) @(negedge clock_50Mhz);
    reset_n = 1'b1;
    wait_ticks(2);

    // 256 completions wrap the counter
    for (int n = 0; n < 256; n++) begin
      button_n[0] = 1'b0;
      wait_state(5'd1, 120, "loop_enter");
      pulse_complete(1);
      button_n[0] = 1'b1;
      wait_ticks(25);
      if (n == 254) chk("count_255", 32'(debug_string[23:16]), 32'd255);
    end
    chk("count_wrap", 32'(debug_string[23:16]), 32'd0);
    chk("wrap_last", 32'(debug_string[12:8]), 32'd1);

    // watchdog behaviour
    button_n[0] = 1'b0;
    wait_state(5'd1, 120, "wd_enter");
    wait_ticks(3);
    button_n[0] = 1'b1;
    wait_ticks(130);
`ifdef MUSICBOX_STATE_TIMEOUT_EN
    chk("wd_timeout_idle", 32'(current_state), 32'd0);
    chk("wd_flag_set", 32'(debug_string[31]), 32'd1);
    button_n[0] = 1'b0;
    wait_state(5'd1, 120, "wd_reenter");
    pulse_complete(1);
    button_n[0] = 1'b1;
    wait_ticks(25);
    chk("wd_flag_sticky", 32'(debug_string[31]), 32'd1);
`else
    chk("no_wd_stays", 32'(current_state), 32'd1);
    chk("no_wd_flag", 32'(debug_string[31]), 32'd0);
    button_n[0] = 1'b0;
    wait_state(5'd0, 120, "no_wd_abort");
    button_n[0] = 1'b1;
    wait_ticks(25);
    chk("no_wd_flag_end", 32'(debug_string[31]), 32'd0);
`endif

    repeat (3) @(negedge clock_50Mhz);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/music_box_state_controller.md
Name: music_box_state_controller

Overview:
- Top-level mode sequencer for the music box; sits directly upstream of the per-mode state modules (play song 1, play song 2, play recording, make recording).
- Turns debounced push-button presses into a 5-bit current_state broadcast to every mode module.
- Returns to DoNothing when the active mode raises its completion flag, or when the user aborts.

Parameters:
- DEBOUNCE_MS, 20: number of 1 ms ticks a raw button level must hold before it is accepted.
- TIMEOUT_MS, 60000: watchdog limit in ticks; used only with MUSICBOX_STATE_TIMEOUT_EN.

Ports:
- clock_50Mhz  in  1: sole clock; all flops are on its rising edge.
- reset_n  in  1: reset, asynchronous and active-low.
- tick_1khz  in  1: one-cycle strobe, once per ms, synchronous to clock_50Mhz.
- button_n  in  4: raw active-low keys, asynchronous; key k selects state k+1.
- state_complete  in  5: completion flags from the mode modules, indexed by state number; bit 0 is ignored.
- current_state  out  5: encoded mode (see package).
- state_entered  out  1: one-cycle pulse on any change of current_state.
- debug_string  out  32: status word.

Behaviour:
- Reset values: current_state=0 (DoNothing), state_entered=0, debug_string=0, all debouncers stable-released, all counters 0.
- Input conditioning:
  - Each button_n bit passes a 2-flop synchroniser, then a debouncer.
  - The debouncer's stable level changes only after the synchronised level differs from it for DEBOUNCE_MS consecutive ticks.
  - The difference counter clears whenever the levels agree.
  - press[k] is a one-cycle pulse on the stable 1->0 transition.
- States: IDLE(0), SONG1(1), SONG2(2), PLAYREC(3), MAKEREC(4). Codes 5-31 are illegal; if ever reached, the next cycle goes to IDLE.
- IDLE: press[k] moves to state k+1 on the next clock. With simultaneous presses, the lowest k wins.
- Active state S:
  - state_complete[S]==1 -> IDLE next clock.
  - press[S-1] (the same key again) -> IDLE (abort).
  - Other presses are ignored.
  - state_complete bits for any state other than S are ignored.
  - If completion and abort occur in the same cycle, completion wins; this matters only for the completion count.
- No direct active->active transitions; every change of mode passes through IDLE for at least 1 cycle.
- state_entered is registered and asserted in the same cycle current_state takes its new value.
- debug_string:
  - [4:0] current_state.
  - [12:8] last non-idle state exited.
  - [23:16] completion count, 8-bit, wraps 255->0; incremented on completion exits only.
  - [31] timeout sticky flag.
  - All other bits 0.
- Reset asserted mid-mode forces IDLE asynchronously. The mode modules see state 0 and self-clear.

Optional Feature:
- Macro MUSICBOX_STATE_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog clears on entry to any active state and increments on tick_1khz while active.
  - When it reaches TIMEOUT_MS: force IDLE, set debug_string[31]. Bit 31 is cleared only by reset.
  - Completion or abort in the same cycle takes precedence and does not set the flag.
- Undefined: no watchdog logic; debug_string[31] is tied to 0.

Decomposition:
- Package music_box_pkg holds:
  - typedef enum logic [4:0] music_box_state_t {IDLE=0, SONG1=1, SONG2=2, PLAYREC=3, MAKEREC=4}.
  - NUM_BUTTONS=4.
  - Debug field bit positions.
  - Mode modules compare against these enum values.
- Sub-module button_debouncer (one instance per key): synchroniser, debounce counter and press pulse.

Test Plan:
- Reset release, no keys, 1000 ticks -> current_state=0, debug_string=0, state_entered never pulses.
- Key 3 low for 25 ticks (DEBOUNCE_MS=20) -> current_state=4 about 20 ticks after the press, one state_entered pulse; glitch low for 5 ticks -> no change.
- In state 4, drive state_complete[4]=1 for 1 cycle -> IDLE next clock, debug_string[12:8]=4, [23:16]=1; state_complete[2]=1 while in state 4 -> ignored.
- Keys 1 and 2 pressed in the same debounced cycle from IDLE -> current_state=2; key 1 again -> IDLE, completion count unchanged.
- Assert reset_n=0 asynchronously mid-state 3 -> current_state=0 before the next clock edge; 256 completions -> count wraps to 0.
- With MUSICBOX_STATE_TIMEOUT_EN and TIMEOUT_MS=100: enter state 1 with no completion -> IDLE after 100 ticks, debug_string[31]=1 persists; without the macro -> remains in state 1 and bit 31 stays 0.
